// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// segment table, line polarities and the per-slot display record.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic       AN_ON   = 1'b0;
  localparam logic       AN_OFF  = 1'b1;
  localparam logic       DP_ON   = 1'b0;
  localparam logic       DP_OFF  = 1'b1;

  // Negative-logic segments g..a for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [6:0] seg_n;
    logic       dp_n;
    logic       dark;
  } slot_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_nibble_decode.sv
// Combinational hex nibble to negative-logic seven-segment decode.
module ssd_nibble_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed value, round-robin
// scan with a guard cycle per slot, leading-zero suppression, blanking and blink.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  load,
  input  logic                  lzs_en,
  input  logic                  blink_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = idx_width(DIGITS);
  localparam int FW = idx_width(BLINK_FRAMES);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q, mask_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                phase_q, phase_d;
  logic                first_q;
  slot_t               slot_q, slot_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;

  logic                slot_end, frame_end, capture, dark_sel;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS:1]     zero_run;
  logic [DIGITS-1:0]   supp;
  logic [6:0]          seg_dec;

  // zero_run[i]: nibbles i..DIGITS-1 are zero and carry no decimal point.
  assign zero_run[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi] = value_q[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign supp[gi] = 1'b0;
    end else begin : g_upper
      assign zero_run[gi] = zero_run[gi+1] & (nib[gi] == 4'h0) & ~dp_q[gi];
      assign supp[gi]     = lzs_en & zero_run[gi];
    end
  end

  ssd_nibble_decode u_dec (
    .nibble_i (nib[idx_d]),
    .seg_n_o  (seg_dec)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frm_d     = frm_q;
    if (frame_end) frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
    phase_d   = phase_q ^ (frame_end && (frm_q == FRM_LAST));
  end

  // The slot record is taken on entry to a guard cycle, and also on the first
  // edge after reset since reset itself stands in for that slot's guard entry.
  always_comb begin
    capture  = (cnt_d == '0) || first_q;
    dark_sel = mask_q[idx_d] | supp[idx_d] | (blink_en & phase_d);
    slot_d   = slot_q;
    if (capture) begin
      slot_d.dark  = dark_sel;
      slot_d.seg_n = dark_sel ? SEG_OFF : seg_dec;
      slot_d.dp_n  = (!dark_sel && dp_q[idx_d]) ? DP_ON : DP_OFF;
    end
    an_n_d = {DIGITS{AN_OFF}};
    if ((cnt_d != '0) && !slot_d.dark) an_n_d[idx_d] = AN_ON;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      first_q <= 1'b1;
      slot_q  <= '{seg_n: SEG_OFF, dp_n: DP_OFF, dark: 1'b0};
      an_n_q  <= {DIGITS{AN_OFF}};
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
        mask_q  <= blank_mask;
      end
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      first_q <= 1'b0;
      slot_q  <= slot_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = slot_q.seg_n;
  assign dp_n  = slot_q.dp_n;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
// plus a single-digit instance with REFRESH_DIV=2.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, blank_mask = '0;
  logic        load = 1'b0, lzs_en = 1'b0, blink_en = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  logic [3:0]  value1 = '0;
  logic [0:0]  dp_in1 = '0, blank_mask1 = '0;
  logic [6:0]  seg_n1;
  logic        dp_n1;
  logic [0:0]  an_n1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
    .load(load), .lzs_en(lzs_en), .blink_en(blink_en),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  ssd_scan_driver #(.DIGITS(1), .REFRESH_DIV(2), .BLINK_FRAMES(1)) dut1 (
    .clk(clk), .reset(reset), .value(value1), .dp_in(dp_in1), .blank_mask(blank_mask1),
    .load(load), .lzs_en(lzs_en), .blink_en(1'b0),
    .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    checks++;
    assert (an_n === an) else begin
      errors++; $error("FAIL %s an_n: got %h expected %h", tag, an_n, an);
    end
    checks++;
    assert (seg_n === seg) else begin
      errors++; $error("FAIL %s seg_n: got %h expected %h", tag, seg_n, seg);
    end
    checks++;
    assert (dp_n === dp) else begin
      errors++; $error("FAIL %s dp_n: got %b expected %b", tag, dp_n, dp);
    end
    $display("t=%0t %s an_n=%h seg_n=%h dp_n=%b", $time, tag, an_n, seg_n, dp_n);
  endtask

  task automatic expect1(input string tag, input logic an, input logic [6:0] seg);
    checks++;
    assert (an_n1 === an) else begin
      errors++; $error("FAIL %s an_n1: got %b expected %b", tag, an_n1, an);
    end
    checks++;
    assert (seg_n1 === seg) else begin
      errors++; $error("FAIL %s seg_n1: got %h expected %h", tag, seg_n1, seg);
    end
    $display("t=%0t %s an_n1=%b seg_n1=%h", $time, tag, an_n1, seg_n1);
  endtask

  // Guard cycle then three on-cycles of one digit slot.
  task automatic run_slot(input string tag, input logic [3:0] an_on, input logic [6:0] seg, input logic dp);
    tick();
    expect_out({tag, "/guard"}, 4'hF, seg, dp);
    repeat (3) begin
      tick();
      expect_out(tag, an_on, seg, dp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b0; lzs_en = 1'b0; blink_en = 1'b0;
    value = '0; dp_in = '0; blank_mask = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // After release the reset state is the digit-0 guard; digit 0 shows the cleared shadow.
  task automatic first_slot(input string tag);
    expect_out({tag, "/rst"}, 4'hF, 7'h7F, 1'b1);
    tick();
    load = 1'b0;
    expect_out({tag, "/d0"}, 4'hE, 7'h40, 1'b1);
    repeat (2) begin
      tick();
      expect_out({tag, "/d0"}, 4'hE, 7'h40, 1'b1);
    end
  endtask

  initial begin
    // Basic scan of 12AF
    do_reset();
    value = 16'h12AF; load = 1'b1;
    first_slot("scan");
    run_slot("scan d1", 4'hD, 7'h08, 1'b1);
    run_slot("scan d2", 4'hB, 7'h24, 1'b1);
    run_slot("scan d3", 4'h7, 7'h79, 1'b1);
    run_slot("scan d0", 4'hE, 7'h0E, 1'b1);

    // Leading-zero suppression
    do_reset();
    value = 16'h0005; lzs_en = 1'b1; load = 1'b1;
    first_slot("lzs");
    run_slot("lzs d1", 4'hF, 7'h7F, 1'b1);
    run_slot("lzs d2", 4'hF, 7'h7F, 1'b1);
    run_slot("lzs d3", 4'hF, 7'h7F, 1'b1);
    run_slot("lzs d0", 4'hE, 7'h12, 1'b1);

    do_reset();
    value = 16'h0005; dp_in = 4'b0100; lzs_en = 1'b1; load = 1'b1;
    first_slot("lzsdp");
    run_slot("lzsdp d1", 4'hD, 7'h40, 1'b1);
    run_slot("lzsdp d2", 4'hB, 7'h40, 1'b0);
    run_slot("lzsdp d3", 4'hF, 7'h7F, 1'b1);
    run_slot("lzsdp d0", 4'hE, 7'h12, 1'b1);

    // Blink: frames 0,1 lit, 2,3 dark; drop blink_en mid-slot in frame 3
    do_reset();
    value = 16'h12AF; blink_en = 1'b1; load = 1'b1;
    first_slot("blink f0");
    run_slot("blink f0 d1", 4'hD, 7'h08, 1'b1);
    run_slot("blink f0 d2", 4'hB, 7'h24, 1'b1);
    run_slot("blink f0 d3", 4'h7, 7'h79, 1'b1);
    run_slot("blink f1 d0", 4'hE, 7'h0E, 1'b1);
    run_slot("blink f1 d1", 4'hD, 7'h08, 1'b1);
    run_slot("blink f1 d2", 4'hB, 7'h24, 1'b1);
    run_slot("blink f1 d3", 4'h7, 7'h79, 1'b1);
    run_slot("blink f2 d0", 4'hF, 7'h7F, 1'b1);
    run_slot("blink f2 d1", 4'hF, 7'h7F, 1'b1);
    run_slot("blink f2 d2", 4'hF, 7'h7F, 1'b1);
    run_slot("blink f2 d3", 4'hF, 7'h7F, 1'b1);
    run_slot("blink f3 d0", 4'hF, 7'h7F, 1'b1);
    tick(); expect_out("blink f3 d1/guard", 4'hF, 7'h7F, 1'b1);
    tick(); expect_out("blink f3 d1", 4'hF, 7'h7F, 1'b1);
    blink_en = 1'b0;
    tick(); expect_out("blink f3 d1 off", 4'hF, 7'h7F, 1'b1);
    tick(); expect_out("blink f3 d1 off", 4'hF, 7'h7F, 1'b1);
    run_slot("blink f3 d2", 4'hB, 7'h24, 1'b1);
    run_slot("blink f3 d3", 4'h7, 7'h79, 1'b1);

    // Load on the edge entering the digit-2 guard
    do_reset();
    value = 16'h0000; load = 1'b1;
    first_slot("ldt");
    run_slot("ldt d1", 4'hD, 7'h40, 1'b1);
    value = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    expect_out("ldt d2/guard", 4'hF, 7'h40, 1'b1);
    repeat (3) begin
      tick(); expect_out("ldt d2", 4'hB, 7'h40, 1'b1);
    end
    run_slot("ldt d3", 4'h7, 7'h0E, 1'b1);
    run_slot("ldt d0", 4'hE, 7'h0E, 1'b1);
    run_slot("ldt d1b", 4'hD, 7'h0E, 1'b1);
    run_slot("ldt d2b", 4'hB, 7'h0E, 1'b1);

    // Asynchronous reset mid-slot
    do_reset();
    value = 16'h12AF; load = 1'b1;
    first_slot("arst");
    run_slot("arst d1", 4'hD, 7'h08, 1'b1);
    tick(); expect_out("arst d2/guard", 4'hF, 7'h24, 1'b1);
    tick(); expect_out("arst d2", 4'hB, 7'h24, 1'b1);
    #1 reset = 1'b1;
    #1 expect_out("arst async", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    first_slot("arst rel");
    run_slot("arst rel d1", 4'hD, 7'h40, 1'b1);

    // Blank mask
    do_reset();
    value = 16'h12AF; blank_mask = 4'b0010; load = 1'b1;
    first_slot("mask");
    run_slot("mask d1", 4'hF, 7'h7F, 1'b1);
    run_slot("mask d2", 4'hB, 7'h24, 1'b1);
    run_slot("mask d3", 4'h7, 7'h79, 1'b1);
    run_slot("mask d0", 4'hE, 7'h0E, 1'b1);
    run_slot("mask d1b", 4'hF, 7'h7F, 1'b1);

    // Single-digit instance, REFRESH_DIV=2
    do_reset();
    value1 = 4'h3; load = 1'b1;
    expect1("one rst", 1'b1, 7'h7F);
    tick();
    load = 1'b0;
    expect1("one c1", 1'b0, 7'h40);
    tick(); expect1("one c2", 1'b1, 7'h30);
    tick(); expect1("one c3", 1'b0, 7'h30);
    tick(); expect1("one c4", 1'b1, 7'h30);
    tick(); expect1("one c5", 1'b0, 7'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide bank of common-anode, negative-logic seven-segment digits. Segment and anode lines are shared across digits.
- Captures a packed hex value into a shadow register and scans the digits round-robin, one digit per slot.
- Adds a per-digit anti-ghost guard cycle, leading-zero suppression, per-digit blanking, decimal points and whole-display blink.
- Sits between the controller's count/state registers and the board display pins.

Parameters:
- DIGITS, 4, number of digits; legal range 1..8.
- REFRESH_DIV, 50000, clocks per digit slot; minimum 2.
- BLINK_FRAMES, 32, scan frames per blink half-period; minimum 1. One frame = DIGITS*REFRESH_DIV clocks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  packed hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_mask  in  DIGITS  1 = force digit i dark.
- load  in  1  capture value/dp_in/blank_mask into shadow on this edge.
- lzs_en  in  1  leading-zero suppression enable.
- blink_en  in  1  blink enable.
- seg_n  out  7  segments g..a on bits 6..0; 0 = lit.
- dp_n  out  1  decimal point; 0 = lit.
- an_n  out  DIGITS  anode enables; 0 = digit on; at most one bit low.

Behaviour:
- Reset (async, immediate):
  - Shadow registers, slot counter, digit index and blink phase all cleared to 0.
  - an_n all 1, seg_n 7'h7F, dp_n 1.
  - Reset asserted mid-scan aborts the slot with no glitch beyond the async clear.
- Slot counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge, the digit index advances (DIGITS-1 wraps to 0).
  - After reset release, the first slot is digit 0 with counter 0.
- All outputs are registered. In each slot:
  - Cycle 0 (guard): an_n all 1.
  - Cycles 1..REFRESH_DIV-1: an_n has the bit for the current index low, unless the digit is dark.
- seg_n/dp_n capture:
  - Captured on the edge that enters counter 0 (the guard cycle), from the shadow state as of that edge.
  - They then hold constant for the whole slot.
  - A load on that same edge takes effect from the next slot; mid-slot loads never alter the digit being shown.
- Shadow: load=1 captures all three inputs on the edge. Inputs are ignored otherwise.
- Dark digit: the digit is dark if blank_mask[i] is set, if it is suppressed, or if blink hides it. A dark digit keeps an_n all 1 for the entire slot; seg_n=7F and dp_n=1.
- Leading-zero suppression (lzs_en=1):
  - Digit i is suppressed if nibbles i..DIGITS-1 are all zero and i>0.
  - Digit 0 is never suppressed.
  - A dp_in set on a digit stops suppression at that digit and all digits below it.
- Blink:
  - The phase toggles on the last clock of every BLINK_FRAMES-th frame.
  - When blink_en=1 and phase=1, all digits are dark.
  - When blink_en=0, the phase keeps running but is ignored.
- Decode, nibble hex -> seg_n hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E.
- Width rules:
  - Counter width is clog2(REFRESH_DIV); index width is max(1, clog2(DIGITS)); blink frame counter width is clog2(BLINK_FRAMES).
  - DIGITS=1: the index is constant 0 and each slot is still a guard cycle plus REFRESH_DIV-1 on-cycles.

Decomposition:
- Shared package ssd_pkg:
  - 16-entry segment constant table.
  - SEG_OFF=7'h7F.
  - Polarity constants for an_n and dp_n.
  - Function computing index width.
- One combinational sub-module, ssd_nibble_decode: 4-bit in, 7-bit seg_n out, using the package table. Instantiated once on the muxed nibble.
- The top holds the counters, shadow, LZS/blank/blink logic and output registers.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2 unless noted):
- Reset then load value=16'h12AF, flags 0:
  - Each slot: 1 guard cycle (an_n=F), then 3 cycles of an_n=E/D/B/7 with seg_n=0E/08/24/79.
  - Frame = 16 clocks.
- Leading-zero suppression: value=16'h0005, lzs_en=1 -> digits 3..1 dark for their full slots; digit 0 shows 12. With dp_in=4'b0100, digits 2..0 show 40/40/12 and dp_n=0 in the digit 2 slot.
- Blink: blink_en=1 -> frames alternate 2 lit, 2 dark (an_n=F throughout the dark frames). Dropping blink_en mid-dark restores display from the next slot.
- Load timing: load=1 with 16'h0000 -> 16'hFFFF on the edge entering the digit 2 guard -> digit 2 shows 40 for that slot and 0E from the next frame.
- Async reset: assert reset mid-slot with an_n=B -> an_n=F, seg_n=7F, dp_n=1 before the next clk edge. After release, scanning restarts at digit 0 showing 40.
- Mask and DIGITS=1: blank_mask=4'b0010 -> digit 1 never lit. Separately, DIGITS=1, REFRESH_DIV=2 -> an_n alternates 1,0 each cycle.
